// File: rtl/mem_req_arbiter.sv
// Two-master (fetch / load-store) round-robin request arbiter feeding a single axi_rw port.
// Holds the granted request stable until done_i, routes the completion back, flags protocol errors.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int IF_ID      = 0,
    parameter int LS_ID      = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req_i,
    output logic                  if_ready_o,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic [1:0]            if_size_i,
    output logic                  if_resp_o,
    input  logic                  ls_req_i,
    output logic                  ls_ready_o,
    input  logic                  ls_we_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [1:0]            ls_size_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_resp_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_valid_o,
    output logic                  rw_req_o,
    output logic [ADDR_WIDTH-1:0] rw_addr_o,
    output logic [1:0]            rw_size_o,
    output logic [DATA_WIDTH-1:0] data_write_o,
    output logic [ID_WIDTH-1:0]   cpu_id_o,
    input  logic                  done_i,
    input  logic [DATA_WIDTH-1:0] data_read_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_WIDTH-1:0] IF_TAG = ID_WIDTH'(IF_ID);
    localparam logic [ID_WIDTH-1:0] LS_TAG = ID_WIDTH'(LS_ID);

    // Watchdog counts 0..TIMEOUT-1 and saturates; a zero TIMEOUT pins it at 0 and never flags.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state_q, state_d;
    logic            grant_if, grant_ls;
    logic            last_grant_ls_q;
    logic            owner_ls_q;
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On contention the master that did not win last time is granted.
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i && (!ls_req_i || last_grant_ls_q)) begin
                    grant_if = 1'b1;
                end else if (ls_req_i) begin
                    grant_ls = 1'b1;
                end
                if (grant_if || grant_ls) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so ready drops in the same cycle reset is asserted.
    assign if_ready_o = grant_if & reset;
    assign ls_ready_o = grant_ls & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rw_valid_o      <= 1'b0;
            rw_req_o        <= 1'b0;
            rw_addr_o       <= '0;
            rw_size_o       <= '0;
            data_write_o    <= '0;
            cpu_id_o        <= '0;
            rdata_o         <= '0;
            if_resp_o       <= 1'b0;
            ls_resp_o       <= 1'b0;
            err_o           <= 1'b0;
            owner_ls_q      <= 1'b0;
            last_grant_ls_q <= 1'b1;
            wd_q            <= '0;
        end else begin
            if_resp_o <= 1'b0;
            ls_resp_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        rw_valid_o   <= 1'b1;
                        rw_req_o     <= grant_ls & ls_we_i;
                        rw_addr_o    <= grant_ls ? ls_addr_i : if_addr_i;
                        rw_size_o    <= grant_ls ? ls_size_i : if_size_i;
                        data_write_o <= (grant_ls && ls_we_i) ? ls_wdata_i : '0;
                        cpu_id_o     <= grant_ls ? LS_TAG : IF_TAG;
                        owner_ls_q   <= grant_ls;
                        wd_q         <= '0;
                    end
                end
                BUSY: begin
                    if (done_i) begin
                        rw_valid_o      <= 1'b0;
                        rdata_o         <= rw_req_o ? '0 : data_read_i;
                        if_resp_o       <= ~owner_ls_q;
                        ls_resp_o       <= owner_ls_q;
                        last_grant_ls_q <= owner_ls_q;
                        if (id_i != cpu_id_o) begin
                            err_o <= 1'b1;
                        end
                    end else if (wd_q != WD_LAST) begin
                        wd_q <= wd_q + 1'b1;
                    end else if (TIMEOUT != 0) begin
                        err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (done_i && (state_q != BUSY)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
